// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_stage
//  Description : Merges single-cycle ALU results and variable-latency load
//                responses onto the single register-file write port. Loads
//                always win the port. ALU results that lose arbitration wait
//                in a small in-order buffer. Load data is sign- or
//                zero-extended according to the RISC-V load type.
//  Ports       : clk, rst                      - clock, sync active-high reset
//                alu_valid/alu_ready/alu_rd/alu_result - ALU result handshake
//                load_valid/load_rd/load_data/load_funct3/load_offset
//                                              - load response, always taken
//                rf_write_en/rf_write_id/rf_write_data - register file write
//                load_err                      - sticky bad-funct3 flag
//                retire_count                  - results consumed (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int BUF_DEPTH     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDRESS_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_result,
    input  logic                     load_valid,
    input  logic [ADDRESS_WIDTH-1:0] load_rd,
    input  logic [DATA_WIDTH-1:0]    load_data,
    input  logic [2:0]               load_funct3,
    input  logic [1:0]               load_offset,
    output logic                     rf_write_en,
    output logic [ADDRESS_WIDTH-1:0] rf_write_id,
    output logic [DATA_WIDTH-1:0]    rf_write_data,
    output logic                     load_err,
    output logic [31:0]              retire_count
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(BUF_DEPTH);

    // ------------------------------------------------------------------
    // ALU result buffer state
    // ------------------------------------------------------------------
    logic [ADDRESS_WIDTH-1:0] r_buf_rd   [BUF_DEPTH];
    logic [DATA_WIDTH-1:0]    r_buf_data [BUF_DEPTH];
    logic [PTR_W-1:0]         r_head;
    logic [PTR_W-1:0]         r_tail;
    logic [CNT_W-1:0]         r_count;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == C_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Load formatting
    // ------------------------------------------------------------------
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load_fmt;
    logic                  w_load_bad;

    always_comb begin
        w_byte = load_data[7:0];
        case (load_offset)
            2'd0:    w_byte = load_data[7:0];
            2'd1:    w_byte = load_data[15:8];
            2'd2:    w_byte = load_data[23:16];
            default: w_byte = load_data[31:24];
        endcase
        // Halfword select uses only bit 1; misaligned bit 0 is ignored.
        w_half = load_offset[1] ? load_data[31:16] : load_data[15:0];
    end

    always_comb begin
        w_load_fmt = '0;
        w_load_bad = 1'b0;
        case (load_funct3)
            3'b000:  w_load_fmt = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            3'b100:  w_load_fmt = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            3'b001:  w_load_fmt = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            3'b101:  w_load_fmt = {{(DATA_WIDTH-16){1'b0}}, w_half};
            3'b010:  w_load_fmt = load_data;
            default: w_load_bad = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Arbitration: load > buffered ALU head > bypassed ALU result
    // ------------------------------------------------------------------
    logic                     w_empty;
    logic                     w_alu_acc;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_sel_valid;
    logic [ADDRESS_WIDTH-1:0] w_sel_rd;
    logic [DATA_WIDTH-1:0]    w_sel_data;

    // Ready looks only at the registered count; a same-cycle pop does not
    // free a slot early.
    assign alu_ready   = (r_count < C_CNT_FULL);
    assign w_empty     = (r_count == '0);
    assign w_alu_acc   = alu_valid & alu_ready;
    assign w_pop       = ~load_valid & ~w_empty;
    // An accepted ALU result may bypass only when nothing else wants the port.
    assign w_push      = w_alu_acc & (load_valid | ~w_empty);
    assign w_sel_valid = load_valid | ~w_empty | w_alu_acc;

    always_comb begin
        w_sel_rd   = alu_rd;
        w_sel_data = alu_result;
        if (load_valid) begin
            w_sel_rd   = load_rd;
            w_sel_data = w_load_fmt;
        end else if (!w_empty) begin
            w_sel_rd   = r_buf_rd[r_head];
            w_sel_data = r_buf_data[r_head];
        end
    end

    // ------------------------------------------------------------------
    // Buffer update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf_rd[i]   <= '0;
                r_buf_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_buf_rd[r_tail]   <= alu_rd;
                r_buf_data[r_tail] <= alu_result;
                r_tail             <= ptr_next(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_next(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write port, error flag and retire counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write_en   <= 1'b0;
            rf_write_id   <= '0;
            rf_write_data <= '0;
            load_err      <= 1'b0;
            retire_count  <= '0;
        end else begin
            if (w_sel_valid) begin
                // Writes to x0 are consumed and counted but never enabled.
                rf_write_en   <= (w_sel_rd != '0);
                rf_write_id   <= w_sel_rd;
                rf_write_data <= w_sel_data;
                retire_count  <= retire_count + 32'd1;
            end else begin
                rf_write_en   <= 1'b0;
            end
            if (load_valid && w_load_bad) begin
                load_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_stage
//  Description : Self-checking bench for writeback_stage. Table vectors for
//                single-cycle behaviour, hand sequences for collisions,
//                backpressure, x0, load errors and reset, then random traffic
//                checked against a queue-based reference and scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int BUF = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_result;
    logic          load_valid;
    logic [AW-1:0] load_rd;
    logic [DW-1:0] load_data;
    logic [2:0]    load_funct3;
    logic [1:0]    load_offset;
    logic          rf_write_en;
    logic [AW-1:0] rf_write_id;
    logic [DW-1:0] rf_write_data;
    logic          load_err;
    logic [31:0]   retire_count;

    writeback_stage #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .BUF_DEPTH     (BUF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_result    (alu_result),
        .load_valid    (load_valid),
        .load_rd       (load_rd),
        .load_data     (load_data),
        .load_funct3   (load_funct3),
        .load_offset   (load_offset),
        .rf_write_en   (rf_write_en),
        .rf_write_id   (rf_write_id),
        .rf_write_data (rf_write_data),
        .load_err      (load_err),
        .retire_count  (retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          lv;
        logic [AW-1:0] lrd;
        logic [DW-1:0] ldata;
        logic [2:0]    f3;
        logic [1:0]    off;
        logic          av;
        logic [AW-1:0] ard;
        logic [DW-1:0] ares;
        logic          exp_en;
        logic [AW-1:0] exp_id;
        logic [DW-1:0] exp_data;
    } vec_t;

    typedef struct {
        logic          en;
        logic [AW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } alu_t;

    int    total = 0;
    int    bad   = 0;

    exp_t  exp_q[$];
    alu_t  mq[$];
    logic [31:0] m_count;
    logic        m_err;

    vec_t  tbl[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] off,
                                        input logic [31:0] d, output logic err);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b   = 8'(d >> (8 * off));
        h   = 16'(d >> (16 * off[1]));
        err = 1'b0;
        r   = 32'd0;
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd4:    r = {24'd0, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd5:    r = {16'd0, h};
            3'd2:    r = d;
            default: err = 1'b1;
        endcase
        return r;
    endfunction

    // Drives one cycle of stimulus, predicts the write-port result, pushes it
    // to the scoreboard, then pops and checks it one clock later.
    task automatic step(input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldata,
                        input logic [2:0] f3, input logic [1:0] off,
                        input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ares);
        exp_t        e;
        exp_t        got;
        alu_t        a;
        logic        acc;
        logic        sel;
        logic        ferr;
        logic [AW-1:0] srd;
        logic [DW-1:0] sdata;
        @(negedge clk);
        load_valid  = lv;
        load_rd     = lrd;
        load_data   = ldata;
        load_funct3 = f3;
        load_offset = off;
        alu_valid   = av;
        alu_rd      = ard;
        alu_result  = ares;
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, (mq.size() < BUF)});
        acc   = av && (mq.size() < BUF);
        sel   = 1'b0;
        srd   = '0;
        sdata = '0;
        if (lv) begin
            sdata = fmt(f3, off, ldata, ferr);
            if (ferr) m_err = 1'b1;
            srd = lrd;
            sel = 1'b1;
            if (acc) mq.push_back('{ard, ares});
        end else if (mq.size() > 0) begin
            a     = mq.pop_front();
            srd   = a.rd;
            sdata = a.data;
            sel   = 1'b1;
            if (acc) mq.push_back('{ard, ares});
        end else if (acc) begin
            srd   = ard;
            sdata = ares;
            sel   = 1'b1;
        end
        e.en   = sel && (srd != '0);
        e.id   = srd;
        e.data = sdata;
        if (sel) m_count = m_count + 32'd1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk("rf_write_en", {31'd0, rf_write_en}, {31'd0, got.en});
        if (got.en) begin
            chk("rf_write_id", {27'd0, rf_write_id}, {27'd0, got.id});
            chk("rf_write_data", rf_write_data, got.data);
        end
        chk("retire_count", retire_count, m_count);
        chk("load_err", {31'd0, load_err}, {31'd0, m_err});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 3'd0, 2'd0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        alu_valid   = 1'b0;
        load_valid  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        exp_q.delete();
        m_count = 32'd0;
        m_err   = 1'b0;
        chk("rst rf_write_en", {31'd0, rf_write_en}, 32'd0);
        chk("rst rf_write_id", {27'd0, rf_write_id}, 32'd0);
        chk("rst rf_write_data", rf_write_data, 32'd0);
        chk("rst load_err", {31'd0, load_err}, 32'd0);
        chk("rst retire_count", retire_count, 32'd0);
        chk("rst alu_ready", {31'd0, alu_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; alu_valid = 0; alu_rd = 0; alu_result = 0;
        load_valid = 0; load_rd = 0; load_data = 0; load_funct3 = 0; load_offset = 0;
        m_count = 0; m_err = 0;

        //          lv  lrd    ldata         f3    off   av  ard    ares          en  id     data
        tbl[0] = '{1'b0, 5'd0,  32'h0,        3'd0, 2'd0, 1'b1, 5'd5,  32'h1234,     1'b1, 5'd5,  32'h0000_1234};
        tbl[1] = '{1'b1, 5'd3,  32'h0080_0000, 3'd0, 2'd2, 1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'hFFFF_FF80};
        tbl[2] = '{1'b1, 5'd3,  32'h0080_0000, 3'd4, 2'd2, 1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h0000_0080};
        tbl[3] = '{1'b1, 5'd9,  32'h8001_0000, 3'd1, 2'd3, 1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'hFFFF_8001};
        tbl[4] = '{1'b1, 5'd10, 32'h1234_F00D, 3'd5, 2'd0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'h0000_F00D};
        tbl[5] = '{1'b1, 5'd11, 32'hDEAD_BEEF, 3'd2, 2'd1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 32'hDEAD_BEEF};
        tbl[6] = '{1'b1, 5'd12, 32'h0000_007F, 3'd0, 2'd0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h0000_007F};
        tbl[7] = '{1'b1, 5'd13, 32'hAB00_0000, 3'd4, 2'd3, 1'b0, 5'd0,  32'h0,        1'b1, 5'd13, 32'h0000_00AB};
        tbl[8] = '{1'b0, 5'd0,  32'h0,        3'd0, 2'd0, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF};
        tbl[9] = '{1'b0, 5'd0,  32'h0,        3'd0, 2'd0, 1'b1, 5'd0,  32'h5555_5555, 1'b0, 5'd0,  32'h0};

        do_reset();

        // Isolated single-result vectors, each followed by an idle cycle.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].lv, tbl[i].lrd, tbl[i].ldata, tbl[i].f3, tbl[i].off,
                 tbl[i].av, tbl[i].ard, tbl[i].ares);
            chk("tbl en", {31'd0, rf_write_en}, {31'd0, tbl[i].exp_en});
            if (tbl[i].exp_en) begin
                chk("tbl id", {27'd0, rf_write_id}, {27'd0, tbl[i].exp_id});
                chk("tbl data", rf_write_data, tbl[i].exp_data);
            end
            chk("tbl retire", retire_count, 32'(2 * 0 + i + 1));
            idle(1);
        end

        // Collision: load x7 and ALU x8 together, then ALU drains next.
        step(1'b1, 5'd7, 32'h0000_0042, 3'd2, 2'd0, 1'b1, 5'd8, 32'hAA);
        chk("coll first id", {27'd0, rf_write_id}, 32'd7);
        step(1'b0, '0, '0, 3'd0, 2'd0, 1'b0, '0, '0);
        chk("coll second id", {27'd0, rf_write_id}, 32'd8);
        chk("coll second data", rf_write_data, 32'hAA);
        idle(1);
        chk("coll ready after", {31'd0, alu_ready}, 32'd1);

        // Backpressure: loads plus ALU for 3 cycles fills the buffer.
        step(1'b1, 5'd1, 32'h11, 3'd2, 2'd0, 1'b1, 5'd20, 32'hA0);
        step(1'b1, 5'd2, 32'h22, 3'd2, 2'd0, 1'b1, 5'd21, 32'hA1);
        chk("bp ready low", {31'd0, alu_ready}, 32'd0);
        step(1'b1, 5'd3, 32'h33, 3'd2, 2'd0, 1'b1, 5'd22, 32'hA2);
        step(1'b0, '0, '0, 3'd0, 2'd0, 1'b0, '0, '0);
        chk("bp drain0", {27'd0, rf_write_id}, 32'd20);
        step(1'b0, '0, '0, 3'd0, 2'd0, 1'b0, '0, '0);
        chk("bp drain1", {27'd0, rf_write_id}, 32'd21);
        idle(2);

        // Load to x0 is counted but not written; bad funct3 sets sticky error.
        step(1'b1, 5'd0, 32'h1, 3'd2, 2'd0, 1'b0, '0, '0);
        step(1'b1, 5'd4, 32'hFFFF_FFFF, 3'd3, 2'd0, 1'b0, '0, '0);
        chk("err data", rf_write_data, 32'd0);
        chk("err flag", {31'd0, load_err}, 32'd1);
        idle(3);
        step(1'b1, 5'd6, 32'h1, 3'd6, 2'd0, 1'b0, '0, '0);
        step(1'b1, 5'd6, 32'h1, 3'd7, 2'd1, 1'b0, '0, '0);
        do_reset();

        // Reset with two buffered ALU results discards them.
        step(1'b1, 5'd1, 32'h1, 3'd2, 2'd0, 1'b1, 5'd25, 32'hB0);
        step(1'b1, 5'd2, 32'h2, 3'd2, 2'd0, 1'b1, 5'd26, 32'hB1);
        do_reset();
        idle(3);

        // Random mixed traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 3), 5'($urandom), $urandom, 3'($urandom_range(0, 7)),
                 2'($urandom), ($urandom_range(0, 9) < 7), 5'($urandom), $urandom);
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Writeback stage directly upstream of the register file write port. It merges results from the single-cycle execute path (ALU) and the variable-latency load unit onto the one register-file write port. Load data is formatted per RISC-V load type, with sign or zero extension. ALU results are queued in a small in-order buffer when a load takes the port, so the port is never double-driven.

Parameters:
ADDRESS_WIDTH, 5, register index width
DATA_WIDTH, 32, datapath width; load formatting is defined for 32 only
BUF_DEPTH, 2, ALU result buffer entries (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
alu_valid  input  1  ALU result offered
alu_ready  output  1  stage can accept ALU result
alu_rd  input  ADDRESS_WIDTH  ALU destination register
alu_result  input  DATA_WIDTH  ALU result
load_valid  input  1  load response present; always accepted
load_rd  input  ADDRESS_WIDTH  load destination register
load_data  input  DATA_WIDTH  raw aligned memory word
load_funct3  input  3  load type (LB/LH/LW/LBU/LHU)
load_offset  input  2  byte address bits [1:0]
rf_write_en  output  1  register file write enable
rf_write_id  output  ADDRESS_WIDTH  register file write index
rf_write_data  output  DATA_WIDTH  register file write data
load_err  output  1  sticky: unsupported load_funct3 seen
retire_count  output  32  count of accepted results

Behaviour:
- Reset value of every output and state element:
  - rf_write_en=0, rf_write_id=0, rf_write_data=0, load_err=0, retire_count=0.
  - Buffer is emptied. Reset mid-operation discards buffered ALU results.
  - alu_ready=1 in the first cycle after reset.
- alu_ready = (buffer count < BUF_DEPTH). It depends only on registered count, with no same-cycle pop lookahead.
- ALU acceptance = alu_valid & alu_ready. Loads are always accepted; there is no load_ready.
- Per-cycle arbitration for the write port. Exactly one source is selected; the outputs register it and drive it in the next cycle (latency 1).
  - 1. load_valid: load is selected. An accepted ALU result is pushed to the buffer tail.
  - 2. else buffer non-empty: head is popped and selected. An accepted ALU result is pushed to the tail in the same cycle.
  - 3. else accepted ALU result: bypasses the buffer and is selected directly.
  - 4. else rf_write_en=0 next cycle; rf_write_id and rf_write_data hold their previous values.
- ALU results retire in acceptance order. Loads may overtake buffered ALU results; hazard checking upstream guarantees no WAW between them.
- x0 suppression: a selected result with rd=0 is consumed and counted, but rf_write_en stays 0.
- Load formatting on load_data, using byte b=load_offset and half h=load_offset[1]:
  - 000 LB: sign-extend byte b.
  - 100 LBU: zero-extend byte b.
  - 001 LH: sign-extend half h; load_offset[0] is ignored.
  - 101 LHU: zero-extend half h.
  - 010 LW: full word; load_offset is ignored.
  - 011/110/111: write 0 and set load_err, which stays set until reset.
- retire_count increments by 1 for every selected result (load or ALU, including x0). It wraps modulo 2^32.
- Buffer storage is pointer-based with wrap-around at BUF_DEPTH. count is updated as +1 on push only, -1 on pop only, and unchanged on push+pop.
- Full buffer with a load arriving: no ALU acceptance (alu_ready=0). The load still writes.

Test Plan:
- Reset, then alu_valid with rd=5, result=0x1234 -> next cycle rf_write_en=1, id=5, data=0x1234; retire_count=1.
- Load-byte sign extension: load_valid, funct3=000, offset=2, data=0x00800000, rd=3 -> next cycle write x3=0xFFFFFF80. Repeat with funct3=100 -> 0x00000080.
- Collision: load (rd=7) and ALU (rd=8, 0xAA) in the same cycle, then idle -> cycle+1 writes x7, cycle+2 writes x8=0xAA. Buffer is empty afterwards and alu_ready=1.
- Backpressure: 3 consecutive cycles of load_valid plus alu_valid (BUF_DEPTH=2) -> alu_ready=0 in the 3rd cycle. Once loads stop, buffered ALU results drain in order over 2 cycles.
- x0 and error: ALU rd=0 -> rf_write_en stays 0 but retire_count increments. Load with funct3=011 -> writes 0 and load_err=1, which persists until rst.
- Reset mid-operation: buffer holding 2 entries, assert rst for 1 cycle -> no writes afterwards, retire_count=0, alu_ready=1.
